vga_pixel_fetch: RTL and testbench
==================================

// Module: vga_pixel_fetch
// PURPOSE
//  Downstream of vgacontroller. Turns its pixel coordinates (x_pos, y_pos, display_en, hs, vs)
//  into colour. Reads a scaled, double-buffered framebuffer through a synchronous RAM port.
//  Maps each stored pixel through a palette and outputs 12-bit RGB.
//  Delays hs/vs so that they stay aligned with the RGB output at the DAC/pins.
// PARAMETERS
//  FB_W    160  framebuffer width in stored pixels
//  FB_H    120  framebuffer height in stored pixels
//  XSHIFT  1    horizontal upscale: fb_x = x_pos >> XSHIFT
//  YSHIFT  2    vertical upscale:   fb_y = y_pos >> YSHIFT
//  ADDR_W  16   fb_addr width; MSB = buffer select, low ADDR_W-1 bits = fb_y*FB_W+fb_x
//  SYNC_POL 0   active level of hs/vs (0 = active-low), same for inputs and outputs
// PORTS
//  clk          in   1       pixel clock, rising edge
//  rst          in   1       asynchronous, active-low reset
//  x_pos        in   9       horizontal pixel coordinate from vgacontroller
//  y_pos        in   10      vertical pixel coordinate from vgacontroller
//  display_en   in   1       active-video flag from vgacontroller
//  hs / vs      in   1       sync from vgacontroller
//  buf_sel      in   1       requested display buffer, applied at next frame start
//  border_color in   12      RGB driven for active pixels outside the framebuffer
//  fb_addr      out  ADDR_W  framebuffer read address
//  fb_rdata     in   8       RAM data: palette index, valid 1 clk after fb_addr
//  pal_we       in   1       palette write strobe
//  pal_waddr    in   8       palette write index
//  pal_wdata    in   12      palette write data, {R4,G4,B4}
//  rgb          out  12      pixel colour {R4,G4,B4}
//  hs_o / vs_o  out  1       sync outputs, delayed to align with rgb
//  frame_start  out  1       1-clk pulse when the active buffer is latched
// BEHAVIOUR
//  Reset (rst=0, async):
//   - rgb=0, fb_addr=0, frame_start=0, active buffer=0, pipeline valids=0.
//   - hs_o and vs_o = ~SYNC_POL (inactive).
//  Pipeline: total latency 3 clks from input sample to rgb/hs_o/vs_o.
//   - S1 (edge N+1): register fb_addr = {act_buf, (y_pos>>YSHIFT)*FB_W + (x_pos>>XSHIFT)}.
//     Also register in_fb = display_en & fb_x<FB_W & fb_y<FB_H, and register de, hs, vs.
//   - S2 (edge N+2): RAM data is presented. Carry in_fb, de, hs and vs forward one stage.
//   - S3 (edge N+3): rgb selection:
//       in_fb       -> palette[fb_rdata]
//       de & ~in_fb -> border_color
//       ~de         -> 12'h000
//     hs_o and vs_o are the inputs delayed exactly 3 clks.
//  Address arithmetic:
//   - Product is computed at ADDR_W-1 bits; no wrap is permitted for in-range coordinates.
//   - Out-of-range coordinates may drive any address; rgb must then come from border or black.
//  Buffer swap:
//   - A vs inactive->active transition is detected on the registered S1 vs.
//   - On that edge: act_buf <= buf_sel, and frame_start=1 for exactly one clk.
//   - buf_sel toggling on the same clk as the edge: the value sampled at that edge wins.
//   - Otherwise buf_sel changes never affect the frame in progress.
//  Palette: 256x12 register/distributed RAM.
//   - Written synchronously when pal_we=1.
//   - Read at S3.
//   - Write and read of the same index in the same clk: the read returns the OLD value.
//   - Reset does not clear palette contents.
//  Reset mid-frame: all of the above reset values apply immediately.
//   - Output resumes correct alignment 3 clks after rst deasserts.
//   - No frame_start is emitted until the next vs active edge.
// CONFIGURATION
//  TEST_PATTERN_EN defined:
//   - Adds input test_pat (1 bit).
//   - When test_pat=1, S3 rgb = {x_pos[8:5], y_pos[8:5], x_pos[8:5]^y_pos[8:5]}.
//     These are the coordinates delayed 3 clks; display_en gating and the border rule still apply.
//   - fb_addr keeps running.
//  TEST_PATTERN_EN undefined: no test_pat port and no pattern logic; behaviour as above only.
// TESTING
//  1. Reset: rst=0 mid-line -> rgb=0, hs_o=vs_o=1, fb_addr=0 within the same clk.
//     After release, alignment is correct at N+3.
//  2. x_pos=10, y_pos=9, de=1, act_buf=0 -> fb_addr=16'd(2*160+5)=325 at N+1.
//     With the RAM model returning 8'h2A and pal[2A]=12'hF0F -> rgb=12'hF0F at N+3.
//  3. x_pos=330, y_pos=100, de=1 (fb_x=165 >= 160), border_color=12'h00F -> rgb=12'h00F at N+3.
//     With de=0 -> rgb=0.
//  4. Sync alignment: pulse hs low for 96 clks -> hs_o is the same pulse shifted by exactly 3 clks.
//     vs is shifted by exactly 3 clks in the same way.
//  5. Buffer swap: buf_sel=1 mid-frame -> fb_addr MSB stays 0 until the vs falling edge.
//     At that edge frame_start pulses for 1 clk and the MSB becomes 1 from then on.
//  6. Palette write pal_we=1, idx 2A, 12'h123 while 2A is being read -> that pixel shows the old colour.
//     The next read of 2A shows 12'h123.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: 3-stage coordinate-to-RGB pipeline over a scaled, double-buffered framebuffer and 256x12 palette.
// Define TEST_PATTERN_EN to add the test_pat input and the coordinate test pattern.
module vga_pixel_fetch #(
  parameter int FB_W = 160,
  parameter int FB_H = 120,
  parameter int XSHIFT = 1,
  parameter int YSHIFT = 2,
  parameter int ADDR_W = 16,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        x_pos,
  input  logic [9:0]        y_pos,
  input  logic              display_en,
  input  logic              hs,
  input  logic              vs,
  input  logic              buf_sel,
  input  logic [11:0]       border_color,
`ifdef TEST_PATTERN_EN
  input  logic              test_pat,
`endif
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_rdata,
  input  logic              pal_we,
  input  logic [7:0]        pal_waddr,
  input  logic [11:0]       pal_wdata,
  output logic [11:0]       rgb,
  output logic              hs_o,
  output logic              vs_o,
  output logic              frame_start
);
  localparam int AW = ADDR_W - 1;
  logic [8:0] fb_x;
  logic [9:0] fb_y;
  logic [AW-1:0] lin;
  logic in_range, swap, act_buf;
  logic in_fb1, de1, hs1, vs1, in_fb2, de2, hs2, vs2;
  logic [11:0] pal [256];
  logic [11:0] px;
  assign fb_x = x_pos >> XSHIFT;
  assign fb_y = y_pos >> YSHIFT;
  assign lin = AW'(32'(fb_y) * FB_W + 32'(fb_x));
  assign in_range = (32'(fb_x) < FB_W) && (32'(fb_y) < FB_H);
  // Frame boundary is the clock at which the registered vs first becomes active
  assign swap = (vs == SYNC_POL) && (vs1 != SYNC_POL);
  always_ff @(posedge clk)
    if (pal_we) pal[pal_waddr] <= pal_wdata;
`ifdef TEST_PATTERN_EN
  logic tp1, tp2;
  logic [11:0] pat1, pat2;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tp1 <= 1'b0;
      tp2 <= 1'b0;
      pat1 <= '0;
      pat2 <= '0;
    end else begin
      tp1 <= test_pat;
      tp2 <= tp1;
      pat1 <= {x_pos[8:5], y_pos[8:5], x_pos[8:5] ^ y_pos[8:5]};
      pat2 <= pat1;
    end
  assign px = tp2 ? pat2 : pal[fb_rdata];
`else
  assign px = pal[fb_rdata];
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fb_addr <= '0;
      act_buf <= 1'b0;
      frame_start <= 1'b0;
      in_fb1 <= 1'b0;
      de1 <= 1'b0;
      hs1 <= ~SYNC_POL;
      vs1 <= ~SYNC_POL;
      in_fb2 <= 1'b0;
      de2 <= 1'b0;
      hs2 <= ~SYNC_POL;
      vs2 <= ~SYNC_POL;
      rgb <= '0;
      hs_o <= ~SYNC_POL;
      vs_o <= ~SYNC_POL;
    end else begin
      fb_addr <= {act_buf, lin};
      act_buf <= swap ? buf_sel : act_buf;
      frame_start <= swap;
      in_fb1 <= display_en && in_range;
      de1 <= display_en;
      hs1 <= hs;
      vs1 <= vs;
      in_fb2 <= in_fb1;
      de2 <= de1;
      hs2 <= hs1;
      vs2 <= vs1;
      rgb <= in_fb2 ? px : de2 ? border_color : 12'h000;
      hs_o <= hs2;
      vs_o <= vs2;
    end
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: randomized + directed scoreboard bench for vga_pixel_fetch against a frame-level model.
module tb_vga_pixel_fetch;
  logic clk = 1'b0, rst = 1'b0;
  logic [8:0] x = '0;
  logic [9:0] y = '0;
  logic de = 1'b0, hs = 1'b1, vs = 1'b1, bsel = 1'b0, pal_we = 1'b0;
  logic [11:0] border = 12'h00F, wdata = '0;
  logic [7:0] waddr = '0;
  logic [15:0] fb_addr;
  logic [7:0] fb_rdata;
  logic [11:0] rgb;
  logic hs_o, vs_o, frame_start;

  vga_pixel_fetch dut (
    .clk(clk), .rst(rst), .x_pos(x), .y_pos(y), .display_en(de), .hs(hs), .vs(vs),
    .buf_sel(bsel), .border_color(border), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
    .pal_we(pal_we), .pal_waddr(waddr), .pal_wdata(wdata), .rgb(rgb), .hs_o(hs_o),
    .vs_o(vs_o), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [65536];
  always @(posedge clk) fb_rdata <= mem[fb_addr];

  typedef struct { int due; bit chk_addr; logic [15:0] addr; bit fs; } a_t;
  typedef struct { int due; bit use_pal; logic [7:0] idx; logic [11:0] fixed; bit hs; bit vs; } p_t;
  typedef struct { int stamp; logic [7:0] a; logic [11:0] d; } w_t;
  a_t aq[$];
  p_t pq[$];
  w_t wq[$];
  logic [11:0] mpal [256];
  int checks = 0, errors = 0, cyc = 0;
  bit ab_m = 1'b0, pvs_m = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", n, cyc, act, exp);
    end
  endtask

  // Expected values come from frame-level rules: address from scaled coords, buffer flips at vs onset
  task automatic drive(input int xi, input int yi, input bit dei, input bit hsi, input bit vsi,
                       input bit bsi, input bit wei, input int wa, input logic [11:0] wd);
    int k, fx, fy;
    bit inr, sw;
    logic [15:0] a;
    p_t p;
    @(negedge clk);
    x = 9'(xi); y = 10'(yi); de = dei; hs = hsi; vs = vsi; bsel = bsi;
    pal_we = wei; waddr = 8'(wa); wdata = wd;
    k = cyc + 1;
    fx = xi / 2; fy = yi / 4;
    inr = fx < 160 && fy < 120;
    a = {ab_m, 15'(fy * 160 + fx)};
    sw = !vsi && pvs_m;
    aq.push_back('{k, inr, a, sw});
    if (sw) ab_m = bsi;
    pvs_m = vsi;
    p.due = k + 2; p.use_pal = dei && inr; p.idx = mem[a];
    p.fixed = dei ? border : 12'h000; p.hs = hsi; p.vs = vsi;
    pq.push_back(p);
    if (wei) wq.push_back('{k, 8'(wa), wd});
  endtask

  initial forever begin
    a_t e;
    p_t p;
    w_t w;
    @(posedge clk);
    #1;
    while (wq.size() > 0 && wq[0].stamp <= cyc - 1) begin
      w = wq.pop_front();
      mpal[w.a] = w.d;
    end
    while (aq.size() > 0 && aq[0].due <= cyc) begin
      e = aq.pop_front();
      if (e.chk_addr) chk("fb_addr", fb_addr, e.addr);
      chk("frame_start", 16'(frame_start), 16'(e.fs));
    end
    while (pq.size() > 0 && pq[0].due <= cyc) begin
      p = pq.pop_front();
      chk("rgb", 16'(rgb), 16'(p.use_pal ? mpal[p.idx] : p.fixed));
      chk("hs_o", 16'(hs_o), 16'(p.hs));
      chk("vs_o", 16'(vs_o), 16'(p.vs));
    end
  end

  task automatic reset_checks();
    chk("rst_rgb", 16'(rgb), 16'h0);
    chk("rst_hs_o", 16'(hs_o), 16'h1);
    chk("rst_vs_o", 16'(vs_o), 16'h1);
    chk("rst_fb_addr", fb_addr, 16'h0);
    chk("rst_frame_start", 16'(frame_start), 16'h0);
  endtask

  task automatic rand_phase(input int n);
    bit hr = 1'b1, vr = 1'b1, br = 1'b0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 15) == 0) hr = ~hr;
      if ($urandom_range(0, 39) == 0) vr = ~vr;
      if ($urandom_range(0, 9) == 0) br = ~br;
      drive($urandom_range(0, 399), $urandom_range(0, 524), $urandom_range(0, 9) < 8, hr, vr, br,
            $urandom_range(0, 3) == 0, $urandom_range(0, 31), 12'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 31));
    mem[325] = 8'h2A;
    repeat (2) @(negedge clk);
    reset_checks();
    rst = 1'b1;
    for (int i = 0; i < 256; i++)
      drive(0, 0, 0, 1, 1, 0, 1, i, i == 8'h2A ? 12'hF0F : 12'($urandom));
    drive(10, 9, 1, 1, 1, 0, 0, 0, 0);
    drive(330, 100, 1, 1, 1, 0, 0, 0, 0);
    drive(330, 100, 0, 1, 1, 0, 0, 0, 0);
    // Same-clock palette write at the read of 2A returns the old colour, later reads the new one
    drive(10, 9, 1, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0, 0, 0);
    drive(10, 9, 1, 1, 1, 0, 1, 8'h2A, 12'h123);
    drive(10, 9, 1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 96; i++) drive($urandom_range(0, 319), $urandom_range(0, 479), 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive($urandom_range(0, 319), $urandom_range(0, 479), 1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive($urandom_range(0, 319), $urandom_range(0, 479), 1, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive($urandom_range(0, 319), $urandom_range(0, 479), 1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive($urandom_range(0, 319), $urandom_range(0, 479), 1, 1, 1, 1, 0, 0, 0);
    drive(20, 20, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive($urandom_range(0, 319), $urandom_range(0, 479), 1, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1, 0, 0, 0, 0);
    border = 12'($urandom);
    rand_phase(3000);
    for (int i = 0; i < 4; i++) drive(100, 100, 1, 0, 1, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    ab_m = 1'b0;
    pvs_m = 1'b1;
    #1 reset_checks();
    @(negedge clk);
    reset_checks();
    @(negedge clk);
    rst = 1'b1;
    rand_phase(1000);
    repeat (4) @(negedge clk);
    chk("queues_drained", 16'(aq.size() + pq.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
